// File: rtl/lvl_pkg.sv
// Shared constants, FSM encoding and slice helpers for the level-state load/store engine.
// Optional feature macro used by the engine: LVL_LDST_SKIP_ZERO_EN.
package lvl_pkg;

    localparam int unsigned NUM_LVLS         = 8;
    localparam int unsigned WIDTH_LVL_STATES = 11;
    localparam int unsigned LVL_IDX_W        = $clog2(NUM_LVLS);
    localparam int unsigned PACKED_W         = NUM_LVLS * WIDTH_LVL_STATES;

    localparam int unsigned DCD_BIN_LSB = 1;
    localparam int unsigned DCD_BIN_W   = 10;
    localparam int unsigned HAS_BKT_BIT = 0;

    typedef enum logic [2:0] {
        StIdle,
        StLdRd,
        StLdCap,
        StLdWr,
        StStWr,
        StDone
    } ldst_state_e;

    // Level 0 sits in the most significant slice of the packed vector.
    function automatic int unsigned slot_lsb(input int unsigned k);
        return WIDTH_LVL_STATES * (NUM_LVLS - 1 - k);
    endfunction

    function automatic logic lvl_is_empty(input logic [WIDTH_LVL_STATES-1:0] w);
        return (w[DCD_BIN_LSB +: DCD_BIN_W] == '0) && !w[HAS_BKT_BIT];
    endfunction

endpackage

// File: rtl/lvl_state_buf.sv
// NUM_LVLS x WIDTH_LVL_STATES slot buffer: clear, parallel load from the packed vector,
// single indexed write, one indexed read and a packed view of all slots.
module lvl_state_buf
    import lvl_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        ld_i,
    input  logic [PACKED_W-1:0]         ld_data_i,
    input  logic                        wr_en_i,
    input  logic [LVL_IDX_W-1:0]        wr_idx_i,
    input  logic [WIDTH_LVL_STATES-1:0] wr_data_i,
    input  logic [LVL_IDX_W-1:0]        rd_idx_i,
    output logic [WIDTH_LVL_STATES-1:0] rd_data_o,
    output logic [PACKED_W-1:0]         packed_o
);

    logic [WIDTH_LVL_STATES-1:0] slots_q [NUM_LVLS];
    logic [WIDTH_LVL_STATES-1:0] slots_d [NUM_LVLS];

    always_comb begin
        slots_d = slots_q;
        if (clr_i) begin
            for (int unsigned k = 0; k < NUM_LVLS; k++) begin
                slots_d[k] = '0;
            end
        end else if (ld_i) begin
            for (int unsigned k = 0; k < NUM_LVLS; k++) begin
                slots_d[k] = ld_data_i[slot_lsb(k) +: WIDTH_LVL_STATES];
            end
        end else if (wr_en_i) begin
            slots_d[wr_idx_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_LVLS; k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

    always_comb begin
        packed_o = '0;
        for (int unsigned k = 0; k < NUM_LVLS; k++) begin
            packed_o[slot_lsb(k) +: WIDTH_LVL_STATES] = slots_q[k];
        end
    end

    assign rd_data_o = slots_q[rd_idx_i];

endmodule

// File: rtl/lvl_state_ldst.sv
// Level-state load/store engine between global level memory and the level-state array.
// Define LVL_LDST_SKIP_ZERO_EN to suppress memory writes of all-zero level words on store.
module lvl_state_ldst
    import lvl_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_load_i,
    input  logic                        start_store_i,
    input  logic [ADDR_W-1:0]           base_lvl_i,
    input  logic [3:0]                  num_lvls_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        wr_states_o,
    output logic [PACKED_W-1:0]         lvl_states_o,
    input  logic [PACKED_W-1:0]         lvl_states_i,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic                        mem_rd_en_o,
    output logic                        mem_wr_en_o,
    output logic [WIDTH_LVL_STATES-1:0] mem_wdata_o,
    input  logic [WIDTH_LVL_STATES-1:0] mem_rdata_i
);

    ldst_state_e state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic [3:0]           n_q, n_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 cap_vld_q, cap_vld_d;
    logic [LVL_IDX_W-1:0] cap_idx_q, cap_idx_d;
    logic [PACKED_W-1:0]  out_q, out_d;

    logic [3:0]                  n_sel;
    logic                        buf_clr;
    logic                        buf_ld;
    logic [WIDTH_LVL_STATES-1:0] buf_rd_data;
    logic [PACKED_W-1:0]         buf_packed;
    logic                        st_wr_en;

    assign n_sel = (num_lvls_i > 4'(NUM_LVLS)) ? 4'(NUM_LVLS) : num_lvls_i;

    lvl_state_buf u_buf (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clr_i     (buf_clr),
        .ld_i      (buf_ld),
        .ld_data_i (lvl_states_i),
        .wr_en_i   (cap_vld_q),
        .wr_idx_i  (cap_idx_q),
        .wr_data_i (mem_rdata_i),
        .rd_idx_i  (k_q[LVL_IDX_W-1:0]),
        .rd_data_o (buf_rd_data),
        .packed_o  (buf_packed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            n_q       <= '0;
            base_q    <= '0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            base_q    <= base_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        base_d    = base_q;
        // Read k returns its word one cycle later; remember where it lands.
        cap_vld_d = (state_q == StLdRd);
        cap_idx_d = k_q[LVL_IDX_W-1:0];
        unique case (state_q)
            StIdle: begin
                if (start_load_i || start_store_i) begin
                    n_d    = n_sel;
                    base_d = base_lvl_i;
                    k_d    = '0;
                    if (n_sel == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = start_load_i ? StLdRd : StStWr;
                    end
                end
            end
            StLdRd: begin
                if (k_q == n_q - 4'd1) begin
                    state_d = StLdCap;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StLdCap: state_d = StLdWr;
            StLdWr:  state_d = StIdle;
            StStWr: begin
                if (k_q == n_q - 4'd1) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // Load wins a simultaneous request; clearing also zeroes slots the load never fills.
        buf_clr     = (state_q == StIdle) && start_load_i;
        buf_ld      = (state_q == StIdle) && !start_load_i && start_store_i;
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StLdWr) || (state_q == StDone);
        wr_states_o = (state_q == StLdWr);
        mem_rd_en_o = (state_q == StLdRd);
`ifdef LVL_LDST_SKIP_ZERO_EN
        st_wr_en    = (state_q == StStWr) && !lvl_is_empty(buf_rd_data);
`else
        st_wr_en    = (state_q == StStWr);
`endif
        mem_wr_en_o = st_wr_en;
        mem_addr_o  = (mem_rd_en_o || mem_wr_en_o) ? base_q + ADDR_W'(k_q) : '0;
        mem_wdata_o = mem_wr_en_o ? buf_rd_data : '0;
        lvl_states_o = (state_q == StLdWr) ? buf_packed : out_q;
        out_d        = lvl_states_o;
    end

endmodule

// File: tb/tb_lvl_state_ldst.sv
// Directed self-checking bench for lvl_state_ldst with a 1-cycle-latency memory model.
module tb_lvl_state_ldst;
    localparam int W = 11;
    localparam int N = 8;
    localparam int PW = W * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_load_i = 1'b0;
    logic          start_store_i = 1'b0;
    logic [15:0]   base_lvl_i = '0;
    logic [3:0]    num_lvls_i = '0;
    logic          busy_o, done_o, wr_states_o;
    logic [PW-1:0] lvl_states_o;
    logic [PW-1:0] lvl_states_i = '0;
    logic [15:0]   mem_addr_o;
    logic          mem_rd_en_o, mem_wr_en_o;
    logic [W-1:0]  mem_wdata_o;
    logic [W-1:0]  mem_rdata_i;

    lvl_state_ldst #(.ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_load_i  (start_load_i),
        .start_store_i (start_store_i),
        .base_lvl_i    (base_lvl_i),
        .num_lvls_i    (num_lvls_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .wr_states_o   (wr_states_o),
        .lvl_states_o  (lvl_states_o),
        .lvl_states_i  (lvl_states_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [65536];
    always @(posedge clk) mem_rdata_i <= mem_rd_en_o ? mem[mem_addr_o] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_busy, n_both, n_idle_bad;
    logic [15:0] rd_addr [$];
    int          rd_cyc [$];
    logic [15:0] wr_addr [$];
    logic [W-1:0] wr_data [$];
    int          wr_cyc [$];
    int          done_cyc [$];
    int          ws_cyc [$];

    // Log DUT activity once per cycle, 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        if (busy_o) n_busy++;
        if (mem_rd_en_o && mem_wr_en_o) n_both++;
        if (!mem_rd_en_o && !mem_wr_en_o && (mem_addr_o != 0 || mem_wdata_o != 0)) n_idle_bad++;
        if (mem_rd_en_o) begin rd_addr.push_back(mem_addr_o); rd_cyc.push_back(cyc); end
        if (mem_wr_en_o) begin
            wr_addr.push_back(mem_addr_o); wr_data.push_back(mem_wdata_o); wr_cyc.push_back(cyc);
        end
        if (done_o) done_cyc.push_back(cyc);
        if (wr_states_o) ws_cyc.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        n_busy = 0;
        rd_addr.delete(); rd_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); ws_cyc.delete();
    endtask

    logic [W-1:0] slot_v [N];
    function automatic logic [PW-1:0] pack_slots();
        logic [PW-1:0] v = '0;
        for (int k = 0; k < N; k++) v[W*(N-k)-1 -: W] = slot_v[k];
        return v;
    endfunction

    task automatic start_xfer(input logic ld, input logic st, input logic [15:0] base,
                              input logic [3:0] n, output int t0);
        @(negedge clk);
        clear_log();
        start_load_i = ld; start_store_i = st; base_lvl_i = base; num_lvls_i = n;
        t0 = cyc;
        @(negedge clk);
        start_load_i = 1'b0; start_store_i = 1'b0;
    endtask

    function automatic int first_or_neg(input int q [$], input int t0);
        return (q.size() == 1) ? q[0] - t0 : -1;
    endfunction

    int          t0;
    logic [3:0]  pat;
    logic [PW-1:0] exp_v;

    initial begin
        n_both = 0; n_idle_bad = 0;
        clear_log();
        for (int a = 0; a < 65536; a++) mem[a] = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_outs", {done_o, wr_states_o, mem_rd_en_o, mem_wr_en_o}, 0);
        check_eq("rst_lvl_states", lvl_states_o, 0);
        check_eq("rst_addr", mem_addr_o, 0);
        rst = 1'b1;

        // Full load of 8 levels.
        for (int k = 0; k < 8; k++) mem[16'h0100 + k] = 11'h400 | 11'(k);
        start_xfer(1'b1, 1'b0, 16'h0100, 4'd8, t0);
        repeat (14) @(negedge clk);
        check_eq("ld8_nrd", rd_addr.size(), 8);
        for (int k = 0; k < 8 && k < rd_addr.size(); k++) begin
            check_eq($sformatf("ld8_rd_addr%0d", k), rd_addr[k], 16'h0100 + k);
            check_eq($sformatf("ld8_rd_cyc%0d", k), rd_cyc[k] - t0, 1 + k);
        end
        check_eq("ld8_done", first_or_neg(done_cyc, t0), 10);
        check_eq("ld8_ws", first_or_neg(ws_cyc, t0), 10);
        check_eq("ld8_busy", n_busy, 10);
        check_eq("ld8_nwr", wr_addr.size(), 0);
        for (int k = 0; k < 8; k++) slot_v[k] = 11'h400 | 11'(k);
        check_eq("ld8_states", lvl_states_o, pack_slots());

        // Partial load: slots beyond n must come back zero.
        for (int k = 0; k < 8; k++) mem[16'h0200 + k] = 11'h7FF;
        start_xfer(1'b1, 1'b0, 16'h0200, 4'd3, t0);
        repeat (14) @(negedge clk);
        check_eq("ld3_nrd", rd_addr.size(), 3);
        check_eq("ld3_done", first_or_neg(done_cyc, t0), 5);
        for (int k = 0; k < 8; k++) slot_v[k] = (k < 3) ? 11'h7FF : 11'h000;
        exp_v = pack_slots();
        check_eq("ld3_states", lvl_states_o, exp_v);

        // n = 0: immediate done, no access, array untouched.
        start_xfer(1'b1, 1'b0, 16'h0300, 4'd0, t0);
        repeat (6) @(negedge clk);
        check_eq("n0_done", first_or_neg(done_cyc, t0), 1);
        check_eq("n0_access", rd_addr.size() + wr_addr.size() + ws_cyc.size(), 0);
        check_eq("n0_states", lvl_states_o, exp_v);

        // Store with address wrap; input changes after the start must not matter.
        for (int k = 0; k < 8; k++) slot_v[k] = (k < 4) ? 11'(k + 1) : 11'h2AA;
        lvl_states_i = pack_slots();
        start_xfer(1'b0, 1'b1, 16'hFFFE, 4'd4, t0);
        lvl_states_i = '1;
        repeat (14) @(negedge clk);
        check_eq("st_nwr", wr_addr.size(), 4);
        for (int k = 0; k < 4 && k < wr_addr.size(); k++) begin
            check_eq($sformatf("st_addr%0d", k), wr_addr[k], 16'(16'hFFFE + k));
            check_eq($sformatf("st_data%0d", k), wr_data[k], 11'(k + 1));
            check_eq($sformatf("st_cyc%0d", k), wr_cyc[k] - t0, 1 + k);
        end
        check_eq("st_done", first_or_neg(done_cyc, t0), 5);
        check_eq("st_busy", n_busy, 5);
        check_eq("st_nrd_ws", rd_addr.size() + ws_cyc.size(), 0);

        // Simultaneous requests plus a store during the load.
        for (int k = 0; k < 4; k++) mem[16'h0300 + k] = 11'h011 + 11'(k);
        start_xfer(1'b1, 1'b1, 16'h0300, 4'd4, t0);
        start_store_i = 1'b1;
        @(negedge clk);
        start_store_i = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("arb_nrd", rd_addr.size(), 4);
        check_eq("arb_nwr", wr_addr.size(), 0);
        check_eq("arb_done", first_or_neg(done_cyc, t0), 6);
        check_eq("arb_ws", ws_cyc.size(), 1);

        // Reset in the middle of a load.
        start_xfer(1'b1, 1'b0, 16'h0100, 4'd8, t0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mrst_busy", busy_o, 0);
        check_eq("mrst_rd", mem_rd_en_o, 0);
        check_eq("mrst_addr", mem_addr_o, 0);
        check_eq("mrst_states", lvl_states_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("mrst_no_ws", ws_cyc.size() + done_cyc.size(), 0);
        start_xfer(1'b1, 1'b0, 16'h0100, 4'd8, t0);
        repeat (14) @(negedge clk);
        check_eq("post_rst_done", first_or_neg(done_cyc, t0), 10);
        for (int k = 0; k < 8; k++) slot_v[k] = 11'h400 | 11'(k);
        check_eq("post_rst_states", lvl_states_o, pack_slots());

        // Store containing zero words.
        for (int k = 0; k < 8; k++) slot_v[k] = 11'h000;
        slot_v[0] = 11'h005;
        slot_v[2] = 11'h006;
        lvl_states_i = pack_slots();
        start_xfer(1'b0, 1'b1, 16'h0500, 4'd4, t0);
        repeat (12) @(negedge clk);
        pat = '0;
        foreach (wr_cyc[i]) begin
            if (wr_cyc[i] - t0 >= 1 && wr_cyc[i] - t0 <= 4) pat[wr_cyc[i] - t0 - 1] = 1'b1;
        end
`ifdef LVL_LDST_SKIP_ZERO_EN
        check_eq("skip_pattern", pat, 4'b0101);
`else
        check_eq("skip_pattern", pat, 4'b1111);
`endif
        check_eq("skip_done", first_or_neg(done_cyc, t0), 5);

        check_eq("never_rd_and_wr", n_both, 0);
        check_eq("idle_addr_data_zero", n_idle_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvl_state_ldst.md
Name: lvl_state_ldst

Overview:
- Load/store engine on the far side of the Sat Engine level-state bus.
- On a bin switch it reads up to NUM_LVLS saved level words (dcd_bin[9:0], has_bkt) from global level memory, then drives a packed vector plus a one-cycle wr_states strobe into the level-state array.
- On a bin save it snapshots the array's packed output and writes it back to memory, one level per cycle.

Parameters:
- NUM_LVLS, 8, levels held in the engine
- WIDTH_LVL_STATES, 11, bits per level word: {dcd_bin[9:0], has_bkt}
- ADDR_W, 16, global level-memory address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start_load_i  in  1  one-cycle request: memory -> engine
- start_store_i  in  1  one-cycle request: engine -> memory
- base_lvl_i  in  ADDR_W  global level address of engine level 0; sampled at start
- num_lvls_i  in  4  levels to transfer, 0..15; sampled at start
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- wr_states_o  out  1  one-cycle strobe to the array's wr_states
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS  packed states to the array
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  packed states from the array
- mem_addr_o  out  ADDR_W  memory address
- mem_rd_en_o  out  1  read enable; data returns on mem_rdata_i next cycle
- mem_wr_en_o  out  1  write enable
- mem_wdata_o  out  WIDTH_LVL_STATES  write data
- mem_rdata_i  in  WIDTH_LVL_STATES  read data, 1-cycle latency

Behaviour:
- Packing: level k occupies bits [W*(NUM_LVLS-k)-1 : W*(NUM_LVLS-1-k)]. Level 0 is the MSB slice.
- Reset (rst=0, asynchronous):
  - State returns to IDLE; slot buffer is cleared.
  - All outputs are 0, including lvl_states_o.
  - A transfer in flight is abandoned; no further memory access is issued.
- Starting a transfer:
  - Requests are sampled only in IDLE. Requests arriving while busy are ignored.
  - If start_load_i and start_store_i are high together, the load is taken and the store is dropped.
  - n = min(num_lvls_i, NUM_LVLS).
- FSM states: IDLE, LD_RD, LD_CAP, LD_WR, ST_WR, DONE.
- Load, start sampled at cycle T:
  - T+1..T+n (LD_RD): mem_rd_en_o=1, mem_addr_o = base+k for k=0..n-1.
  - The word for read k is captured into slot k one cycle later. The last capture happens at T+n+1 (LD_CAP).
  - Slots k>=n are forced to 0 at T+1.
  - T+n+2 (LD_WR): wr_states_o=1 and done_o=1; lvl_states_o is valid.
  - busy_o is high from T+1 through T+n+2.
  - lvl_states_o holds the buffer contents until the next load completes or reset.
- Store, start sampled at cycle T:
  - lvl_states_i is snapshotted into the buffer at T; later changes to lvl_states_i do not matter.
  - T+1..T+n (ST_WR): mem_wr_en_o=1, mem_addr_o = base+k, mem_wdata_o = slot k.
  - T+n+1 (DONE): done_o=1.
  - busy_o is high from T+1 through T+n+1.
- n=0: no memory access. T+1 is DONE with done_o=1; wr_states_o is not pulsed.
- Address arithmetic: base+k wraps modulo 2^ADDR_W.
- mem_rd_en_o and mem_wr_en_o are never high in the same cycle.
- Idle levels: mem_addr_o and mem_wdata_o are 0 whenever both enables are low.

Optional Feature:
- Macro: LVL_LDST_SKIP_ZERO_EN.
- Defined: during store, a cycle whose slot word is all-zero drives mem_wr_en_o=0. Address still advances and cycle timing is unchanged, so memory keeps its old contents for that level.
- Undefined: every level in 0..n-1 is written, including zero words.

Decomposition:
- Shared package lvl_pkg holds:
  - NUM_LVLS and WIDTH_LVL_STATES.
  - Field offsets: DCD_BIN_LSB=1, HAS_BKT_BIT=0.
  - The ldst FSM state enum.
  - A slot-index function for the packed-vector slices.
- One sub-module, lvl_state_buf: NUM_LVLS x W register file with indexed write, parallel load from the packed vector, clear, and a packed output.

Test Plan:
- Load: base=0x0100, n=8, memory[0x100+k] = 0x400|k -> reads at T+1..T+8; wr_states_o and done_o at T+10; lvl_states_o slot k = 0x400|k.
- Partial load: n=3, memory returns 0x7FF -> slots 0..2 = 0x7FF, slots 3..7 = 0; exactly 3 reads; done at T+5.
- Store with wrap: base=0xFFFE, n=4, lvl_states_i slots = 0x001, 0x002, 0x003, 0x004 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001 with those data; done at T+5. lvl_states_i changed after T has no effect.
- Arbitration: start_load_i and start_store_i together -> load runs, no writes. start_store_i at T+2 during the load -> ignored.
- Reset mid-load: rst low at T+3 with n=8 -> outputs 0 immediately; no wr_states_o pulse. A fresh load after release completes normally.
- SKIP_ZERO (macro defined): store with slots {0x005, 0, 0x006, 0}, n=4 -> mem_wr_en_o pattern 1,0,1,0; done at T+5. Macro undefined -> pattern 1,1,1,1.
